// File: rtl/imem_responder.sv
// Dual-lane instruction memory responder with fixed read latency,
// redirect flush and a program-load write port.
module imem_responder #(
  parameter int          XLEN     = 32,
  parameter int          DEPTH    = 1024,
  parameter int          LATENCY  = 1,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            imem_ren,
  input  logic [XLEN-1:0] imem_addr0,
  input  logic [XLEN-1:0] imem_addr1,
  input  logic            flush,
  input  logic            load_en,
  input  logic [XLEN-1:0] load_addr,
  input  logic [31:0]     load_data,
  output logic            imem_valid,
  output logic [XLEN-1:0] imem_rdata0,
  output logic [XLEN-1:0] imem_rdata1,
  output logic [XLEN-1:0] imem_pc [1:0],
  output logic [1:0]      imem_err,
  output logic [2:0]      inflight
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc0;
    logic [XLEN-1:0] pc1;
    logic [XLEN-1:0] d0;
    logic [XLEN-1:0] d1;
    logic [1:0]      err;
  } ent_t;

  logic [31:0]        mem [DEPTH];
  logic [LATENCY-1:0] vld;
  logic [LATENCY-1:0] nxt_vld;
  ent_t               ent [LATENCY];
  ent_t               cap;
  logic               accept;
  logic               load_ok;

  function automatic logic bad_addr(input logic [XLEN-1:0] a);
    return (a[1:0] != 2'b00) ||
           ({2'b00, a[XLEN-1:2]} >= XLEN'(DEPTH));
  endfunction

  assign accept  = imem_ren & ~flush;
  assign load_ok = load_en & ~bad_addr(load_addr);

  always_comb begin
    cap        = '0;
    cap.pc0    = imem_addr0;
    cap.pc1    = imem_addr1;
    cap.err[0] = bad_addr(imem_addr0);
    cap.err[1] = bad_addr(imem_addr1);
    cap.d0     = XLEN'(NOP_WORD);
    cap.d1     = XLEN'(NOP_WORD);
    if (!cap.err[0])
      cap.d0 = XLEN'(mem[imem_addr0[AW+1:2]]);
    if (!cap.err[1])
      cap.d1 = XLEN'(mem[imem_addr1[AW+1:2]]);
  end

  // Nonblocking write gives read-before-write on a shared edge
  always_ff @(posedge clk) begin
    if (load_ok)
      mem[load_addr[AW+1:2]] <= load_data;
  end

  always_comb begin
    nxt_vld = '0;
    if (!flush) begin
      nxt_vld[0] = imem_ren;
      for (int i = 1; i < LATENCY; i++)
        nxt_vld[i] = vld[i-1];
    end
  end

  // Data only moves with a valid entry so the last stage holds its value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld      <= '0;
      inflight <= '0;
      for (int i = 0; i < LATENCY; i++)
        ent[i] <= '0;
    end else begin
      vld <= nxt_vld;
      if (flush)
        inflight <= '0;
      else
        inflight <= inflight + {2'b00, accept}
                  - {2'b00, vld[LATENCY-1]};
      if (accept)
        ent[0] <= cap;
      for (int i = 1; i < LATENCY; i++)
        if (vld[i-1] && !flush)
          ent[i] <= ent[i-1];
    end
  end

  assign imem_valid  = vld[LATENCY-1];
  assign imem_rdata0 = ent[LATENCY-1].d0;
  assign imem_rdata1 = ent[LATENCY-1].d1;
  assign imem_pc[0]  = ent[LATENCY-1].pc0;
  assign imem_pc[1]  = ent[LATENCY-1].pc1;
  assign imem_err    = ent[LATENCY-1].err;

endmodule

// File: tb/tb_imem_responder.sv
// Randomised bench for imem_responder at LATENCY 1, 2 and 3,
// checked against a response-schedule reference model.
module tb_imem_responder;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_ren = 1'b0;
  logic        flush = 1'b0;
  logic        load_en = 1'b0;
  logic [31:0] imem_addr0 = '0;
  logic [31:0] imem_addr1 = '0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;

  logic        v   [3];
  logic [31:0] r0  [3];
  logic [31:0] r1  [3];
  logic [31:0] p0  [3];
  logic [31:0] p1  [3];
  logic [1:0]  er  [3];
  logic [2:0]  inf [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [31:0] pc [1:0];
    imem_responder #(
      .XLEN(XLEN), .DEPTH(DEPTH),
      .LATENCY(g + 1), .NOP_WORD(NOP)
    ) u_dut (
      .clk(clk), .reset(reset),
      .imem_ren(imem_ren),
      .imem_addr0(imem_addr0),
      .imem_addr1(imem_addr1),
      .flush(flush),
      .load_en(load_en),
      .load_addr(load_addr),
      .load_data(load_data),
      .imem_valid(v[g]),
      .imem_rdata0(r0[g]),
      .imem_rdata1(r1[g]),
      .imem_pc(pc),
      .imem_err(er[g]),
      .inflight(inf[g])
    );
    assign p0[g] = pc[0];
    assign p1[g] = pc[1];
  end

  logic [31:0] m [DEPTH];
  bit          sv   [3][16];
  logic [31:0] s_p0 [3][16];
  logic [31:0] s_p1 [3][16];
  logic [31:0] s_d0 [3][16];
  logic [31:0] s_d1 [3][16];
  logic [1:0]  s_er [3][16];
  logic [31:0] l_p0 [3];
  logic [31:0] l_p1 [3];
  logic [31:0] l_d0 [3];
  logic [31:0] l_d1 [3];
  logic [1:0]  l_er [3];
  int          n = 0;
  int          nchk = 0;
  int          npass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  function automatic void lane(input logic [31:0] a,
                               output logic [31:0] d,
                               output logic e);
    e = (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
    d = NOP;
    if (!e) d = m[a >> 2];
  endfunction

  function automatic void wipe(input int d);
    for (int s = 0; s < 16; s++) sv[d][s] = 0;
    l_p0[d] = '0; l_p1[d] = '0;
    l_d0[d] = '0; l_d1[d] = '0;
    l_er[d] = '0;
  endfunction

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      int s;
      int cnt;
      string t;
      s = n % 16;
      cnt = 0;
      for (int k = 0; k <= d; k++)
        if (sv[d][(n + k) % 16]) cnt++;
      if (sv[d][s]) begin
        l_p0[d] = s_p0[d][s]; l_p1[d] = s_p1[d][s];
        l_d0[d] = s_d0[d][s]; l_d1[d] = s_d1[d][s];
        l_er[d] = s_er[d][s];
      end
      t = $sformatf("L%0d@%0d", d + 1, n);
      chk({t, " valid"}, 32'(v[d]), 32'(sv[d][s]));
      chk({t, " rdata0"}, r0[d], l_d0[d]);
      chk({t, " rdata1"}, r1[d], l_d1[d]);
      chk({t, " pc0"}, p0[d], l_p0[d]);
      chk({t, " pc1"}, p1[d], l_p1[d]);
      chk({t, " err"}, 32'(er[d]), 32'(l_er[d]));
      chk({t, " inflight"}, 32'(inf[d]), 32'(cnt));
      sv[d][s] = 0;
    end
  endtask

  task automatic step();
    logic [31:0] d0, d1;
    logic        e0, e1;
    @(posedge clk);
    n++;
    lane(imem_addr0, d0, e0);
    lane(imem_addr1, d1, e1);
    for (int d = 0; d < 3; d++) begin
      if (reset) wipe(d);
      else if (flush)
        for (int k = 0; k < 4; k++) sv[d][(n + k) % 16] = 0;
      else if (imem_ren) begin
        int s;
        s = (n + d) % 16;
        sv[d][s] = 1;
        s_p0[d][s] = imem_addr0; s_p1[d][s] = imem_addr1;
        s_d0[d][s] = d0; s_d1[d][s] = d1;
        s_er[d][s] = {e1, e0};
      end
    end
    if (load_en && load_addr[1:0] == 2'b00 &&
        (load_addr >> 2) < DEPTH)
      m[load_addr >> 2] = load_data;
    #1;
    check_all();
  endtask

  task automatic req(input logic r, input logic [31:0] a0,
                     input logic [31:0] a1, input logic f);
    imem_ren = r; imem_addr0 = a0; imem_addr1 = a1; flush = f;
    step();
  endtask

  task automatic idle(input int c);
    imem_ren = 0; flush = 0; load_en = 0;
    repeat (c) step();
  endtask

  task automatic arst();
    imem_ren = 0; flush = 0; load_en = 0;
    reset = 1;
    #1;
    for (int d = 0; d < 3; d++) wipe(d);
    check_all();
    step();
    reset = 0;
  endtask

  function automatic logic [31:0] rnd_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 8) return 32'($urandom_range(0, 63)) << 2;
    if (r == 8)
      return (32'($urandom_range(0, 63)) << 2) |
             32'($urandom_range(1, 3));
    return 32'h1000 + (32'($urandom_range(0, 4095)) << 2);
  endfunction

  initial begin
    for (int d = 0; d < 3; d++) wipe(d);
    repeat (2) step();
    reset = 0;
    idle(1);

    for (int i = 0; i < DEPTH; i++) begin
      load_en = 1;
      load_addr = 32'(i) << 2;
      case (i)
        0: load_data = 32'h0022_1820;
        1: load_data = 32'h2085_0064;
        2: load_data = 32'h40C7_0040;
        3: load_data = 32'h4109_FFF0;
        default: load_data = $urandom;
      endcase
      step();
    end
    idle(2);

    req(1, 32'h0, 32'h4, 0);
    idle(4);

    req(1, 32'h0, 32'h4, 0);
    req(1, 32'h8, 32'hC, 0);
    req(1, 32'h0, 32'h4, 0);
    idle(5);

    req(1, 32'h8, 32'hC, 0);
    req(1, 32'h0, 32'h4, 1);
    req(1, 32'h0, 32'h4, 0);
    idle(5);

    req(1, 32'h2, 32'h1000, 0);
    req(1, 32'h8, 32'h1000, 0);
    idle(5);

    load_en = 1; load_addr = 32'h4; load_data = 32'hDEAD_BEEF;
    req(1, 32'h4, 32'h4, 0);
    load_en = 0;
    idle(3);
    req(1, 32'h4, 32'h4, 0);
    idle(4);

    req(1, 32'h0, 32'h4, 0);
    req(1, 32'h8, 32'hC, 0);
    arst();
    idle(5);
    req(1, 32'h0, 32'h0, 0);
    idle(4);

    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        arst();
      end else begin
        load_en = ($urandom_range(0, 9) == 0);
        load_addr = rnd_addr();
        load_data = $urandom;
        req($urandom_range(0, 3) != 0, rnd_addr(), rnd_addr(),
            $urandom_range(0, 19) == 0);
      end
    end
    idle(5);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
Dual-lane instruction memory responder, and the memory-side end of the fetch/imem request protocol. Each cycle it accepts a paired read request (imem_ren, imem_addr0/1) from fetch and returns both instruction words with their PCs and imem_valid after a fixed, parameterised latency. It supports a flush that kills in-flight responses on redirect, and provides a program-load write port for initialisation. It replaces behavioural memory models in frontend benches and is the synthesizable stand-in for the I-cache.

Parameters:
XLEN, 32, address/data width
DEPTH, 1024, instruction words stored
LATENCY, 1, cycles from request sample to response (legal range 1..4)
NOP_WORD, 32'h0000_0000, data returned for faulting lanes

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
imem_ren  input  1  request valid; addr0/addr1 sampled this cycle
imem_addr0  input  XLEN  lane 0 byte address
imem_addr1  input  XLEN  lane 1 byte address
flush  input  1  drop all in-flight and same-cycle requests
load_en  input  1  program-load write enable
load_addr  input  XLEN  program-load byte address
load_data  input  32  program-load word
imem_valid  output  1  response valid (single-cycle pulse per request)
imem_rdata0  output  XLEN  lane 0 instruction
imem_rdata1  output  XLEN  lane 1 instruction
imem_pc  output  [1:0] x XLEN (unpacked)  PC of each returned lane
imem_err  output  2  per-lane fault (bit i = lane i), qualified by imem_valid
inflight  output  3  count of accepted, not-yet-returned requests

Behaviour:
- Reset (async assert): imem_valid=0, imem_rdata0/1=0, imem_pc[0]/[1]=0, imem_err=0, inflight=0. All pipeline valid bits clear. Memory array contents are not reset.
- Word index is addr[XLEN-1:2]. A lane faults when addr[1:0]!=0 or index>=DEPTH.
  - A faulting lane returns NOP_WORD and sets its imem_err bit.
  - The other lane is unaffected.
- Request pipeline has LATENCY stages. Each stage holds {valid, pc0, pc1, data0, data1, err}.
  - Stage 0 captures on the posedge where imem_ren=1 and flush=0. The memory read happens at capture.
  - Entries advance one stage per cycle. They never stall; fetch has no back-pressure on this interface.
- Latency rule: a request sampled at posedge k drives its outputs from posedge k+LATENCY-1.
  - LATENCY=1: the response is visible in the cycle immediately after the request cycle.
  - imem_pc is always aligned with imem_rdata in the same cycle. It is never delayed by an extra cycle.
- Back-to-back requests each cycle produce back-to-back imem_valid pulses, in order.
- When imem_valid=0, imem_rdata*/imem_pc/imem_err hold their last values. Consumers must qualify with imem_valid.
- Flush:
  - On a posedge with flush=1, every pipeline valid bit clears, including the request sampled on that same edge.
  - imem_valid is 0 in the following cycle.
  - A request on the cycle after flush is accepted normally.
- inflight: +1 on accept, -1 on the cycle the response is emitted. Accept and emit in the same cycle leaves it unchanged. Flush sets it to 0.
  - Maximum value is LATENCY.
- Program load: on a posedge with load_en=1 and an in-range, aligned load_addr, mem[index]<=load_data. Out-of-range or misaligned loads are ignored.
- Load and read of the same word on the same edge: the read returns the old contents (read-before-write).
- Both lanes may address the same word; both return identical data.
- Reset mid-operation: all in-flight requests are discarded and no response is emitted after reset releases. Loaded contents survive.

Test Plan:
- Preload mem[0..3] with 0x00221820, 0x20850064, 0x40C70040, 0x4109FFF0. LATENCY=1, ren at addr0=0x0, addr1=0x4. Next cycle: valid=1, rdata0=0x00221820, rdata1=0x20850064, imem_pc[0]=0x0, imem_pc[1]=0x4, err=00, inflight returns to 0.
- LATENCY=3, ren for 3 consecutive cycles at 0x0/0x4, 0x8/0xC, 0x0/0x4. Three valid pulses starting 2 cycles after the first request; in-order PCs 0x0, 0x8, 0x0; inflight peaks at 3.
- LATENCY=2, ren at 0x8/0xC, flush on the next cycle together with a ren at 0x0/0x4. No valid pulse for either request; inflight=0. A ren at 0x0/0x4 one cycle later returns normally.
- Faults: addr0=0x2 (misaligned), addr1=0x1000 (index 1024 >= DEPTH). Response: valid=1, rdata0=rdata1=NOP_WORD, err=11. Then addr0=0x8, addr1=0x1000 gives rdata0=0x40C70040, err=10.
- Same edge: load_en at 0x4 writing 0xDEADBEEF, and ren at 0x4/0x4. Response rdata0=rdata1=0x20850064. A later read at 0x4 returns 0xDEADBEEF.
- Assert reset while 2 requests are in flight (LATENCY=3). Outputs go to 0 immediately, no valid pulse after release, and mem[0] still reads 0x00221820.
